// File: rtl/commit_sequencer.sv
// Retires branch results strictly in commit_id order onto one registered valid/ready port; 1-cycle latency, stalls heads while the slot is full.
// COMMIT_TIMEOUT_EN adds a stall watchdog (timeout_cycles parameter, timeout_err_o port).
module commit_sequencer #(
  parameter int data_width      = 16,
  parameter int n_branches      = 4,
  parameter int n_blocks        = 256,
  parameter int commit_id_width = 8
`ifdef COMMIT_TIMEOUT_EN
  , parameter int timeout_cycles = 1024
`endif
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  logic [n_branches-1:0]                  in_valid_i,
  output logic [n_branches-1:0]                  in_ready_o,
  input  logic [n_branches*commit_id_width-1:0]  in_commit_id_i,
  input  logic [n_branches*$clog2(n_blocks)-1:0] in_block_i,
  input  logic [n_branches*4-1:0]                in_dest_i,
  input  logic [n_branches*data_width-1:0]       in_result_i,
  input  logic [n_branches-1:0]                  in_writes_ext_i,
  input  logic [n_branches-1:0]                  in_commit_flag_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [$clog2(n_blocks)-1:0]            out_block_o,
  output logic [3:0]                             out_dest_o,
  output logic [data_width-1:0]                  out_result_o,
  output logic                                   out_writes_ext_o,
  output logic                                   out_commit_flag_o,
  output logic [commit_id_width-1:0]             out_commit_id_o,
  output logic [commit_id_width-1:0]             expected_id_o,
  output logic                                   dup_err_o
`ifdef COMMIT_TIMEOUT_EN
  , output logic                                 timeout_err_o
`endif
);

  localparam int NB = n_branches;
  localparam int W  = commit_id_width;
  localparam int BW = $clog2(n_blocks);
  localparam int DW = data_width;
  localparam int GW = (NB > 1) ? $clog2(NB) : 1;

  logic          vld_q, vld_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [3:0]    dst_q, dst_d;
  logic [DW-1:0] res_q, res_d;
  logic          ext_q, ext_d;
  logic          flg_q, flg_d;
  logic [W-1:0]  cid_q, cid_d;
  logic [W-1:0]  exp_q, exp_d;
  logic          dup_q, dup_d;

  logic [NB-1:0] match, grant;
  logic [GW-1:0] gidx;
  logic          dup, slot_free, accept;

  always_comb begin
    match = '0;
    for (int i = 0; i < NB; i++)
      match[i] = in_valid_i[i] && (in_commit_id_i[i*W +: W] == exp_q);
  end

  // Scan high-to-low so the lowest matching branch wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (match[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gidx     = GW'(i);
      end
    end
  end

  assign dup        = |(match & (match - NB'(1)));
  assign slot_free  = ~vld_q | out_ready_i;
  assign in_ready_o = (enable_i && slot_free) ? grant : '0;
  assign accept     = |in_ready_o;

  always_comb begin
    vld_d = vld_q;
    blk_d = blk_q;
    dst_d = dst_q;
    res_d = res_q;
    ext_d = ext_q;
    flg_d = flg_q;
    cid_d = cid_q;
    exp_d = exp_q;
    dup_d = dup_q;
    if (enable_i) begin
      if (accept) begin
        vld_d = 1'b1;
        blk_d = in_block_i[int'(gidx)*BW +: BW];
        dst_d = in_dest_i[int'(gidx)*4 +: 4];
        res_d = in_result_i[int'(gidx)*DW +: DW];
        ext_d = in_writes_ext_i[gidx];
        flg_d = in_commit_flag_i[gidx];
        cid_d = in_commit_id_i[int'(gidx)*W +: W];
        exp_d = exp_q + W'(1);
      end else if (vld_q && out_ready_i) begin
        vld_d = 1'b0;
      end
      // Resync only when nothing is in flight on either side.
      if (clear_i && !vld_q && (in_valid_i == '0))
        exp_d = '0;
      if (dup)
        dup_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      blk_q <= '0;
      dst_q <= '0;
      res_q <= '0;
      ext_q <= 1'b0;
      flg_q <= 1'b0;
      cid_q <= '0;
      exp_q <= '0;
      dup_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      blk_q <= blk_d;
      dst_q <= dst_d;
      res_q <= res_d;
      ext_q <= ext_d;
      flg_q <= flg_d;
      cid_q <= cid_d;
      exp_q <= exp_d;
      dup_q <= dup_d;
    end
  end

  assign out_valid_o       = vld_q;
  assign out_block_o       = blk_q;
  assign out_dest_o        = dst_q;
  assign out_result_o      = res_q;
  assign out_writes_ext_o  = ext_q;
  assign out_commit_flag_o = flg_q;
  assign out_commit_id_o   = cid_q;
  assign expected_id_o     = exp_q;
  assign dup_err_o         = dup_q;

`ifdef COMMIT_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          to_q, to_d;

  // Counts cycles where something is waiting but nothing retires; saturates at the limit.
  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (enable_i) begin
      if (accept || (in_valid_i == '0))
        wd_d = '0;
      else if (wd_q != TW'(timeout_cycles))
        wd_d = wd_q + TW'(1);
      if (wd_d == TW'(timeout_cycles))
        to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_err_o = to_q;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Randomized and directed bench for commit_sequencer against an in-order retirement model.
module tb_commit_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset, enable, clear, out_ready;
  logic [3:0]  in_valid, in_ready, in_writes_ext, in_commit_flag;
  logic [31:0] in_commit_id, in_block;
  logic [15:0] in_dest;
  logic [63:0] in_result;
  logic        out_valid, out_writes_ext, out_commit_flag, dup_err;
  logic [7:0]  out_block, out_commit_id, expected_id;
  logic [3:0]  out_dest;
  logic [15:0] out_result;
`ifdef COMMIT_TIMEOUT_EN
  logic        timeout_err;
`endif

  logic [7:0]  b_id[4];
  logic [7:0]  b_blk[4];
  logic [3:0]  b_dst[4];
  logic [15:0] b_res[4];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_commit_id[i*8 +: 8] = b_id[i];
      in_block[i*8 +: 8]     = b_blk[i];
      in_dest[i*4 +: 4]      = b_dst[i];
      in_result[i*16 +: 16]  = b_res[i];
    end
  end

  commit_sequencer #(
    .data_width(16), .n_branches(4), .n_blocks(256), .commit_id_width(8)
`ifdef COMMIT_TIMEOUT_EN
    , .timeout_cycles(TO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_commit_id_i(in_commit_id),
    .in_block_i(in_block), .in_dest_i(in_dest), .in_result_i(in_result),
    .in_writes_ext_i(in_writes_ext), .in_commit_flag_i(in_commit_flag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_block_o(out_block),
    .out_dest_o(out_dest), .out_result_o(out_result), .out_writes_ext_o(out_writes_ext),
    .out_commit_flag_o(out_commit_flag), .out_commit_id_o(out_commit_id),
    .expected_id_o(expected_id), .dup_err_o(dup_err)
`ifdef COMMIT_TIMEOUT_EN
    , .timeout_err_o(timeout_err)
`endif
  );

  // Reference state: what the write port and sequencer must hold after each edge.
  logic        m_vld, m_ext, m_flg, m_dup, m_to;
  logic [7:0]  m_exp, m_blk, m_cid;
  logic [3:0]  m_dst;
  logic [15:0] m_res;
  int          m_wd;
  logic [3:0]  last_rdy;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  task automatic model_reset();
    m_vld = 0; m_ext = 0; m_flg = 0; m_dup = 0; m_to = 0;
    m_exp = 0; m_blk = 0; m_cid = 0; m_dst = 0; m_res = 0; m_wd = 0;
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic put(input int b, input logic [7:0] id);
    in_valid[b]       = 1'b1;
    b_id[b]           = id;
    b_blk[b]          = 8'($urandom);
    b_dst[b]          = 4'($urandom);
    b_res[b]          = 16'($urandom);
    in_writes_ext[b]  = 1'($urandom);
    in_commit_flag[b] = 1'($urandom);
  endtask

  // One clock: check DUT against the model, advance the model, step to the next falling edge.
  task automatic cyc();
    int g, cnt;
    logic [3:0] rdy;
    logic old_vld;
    #1;
    g = -1; cnt = 0;
    for (int i = 0; i < 4; i++)
      if (in_valid[i] && b_id[i] == m_exp) begin
        cnt++;
        if (g < 0) g = i;
      end
    rdy = (enable && (!m_vld || out_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
    last_rdy = in_ready;
    chk("in_ready", in_ready, rdy);
    chk("in_ready_onehot", 64'($countones(in_ready) <= 1), 1);
    chk("out_valid", out_valid, m_vld);
    chk("expected_id", expected_id, m_exp);
    chk("dup_err", dup_err, m_dup);
    chk("payload", {out_block, out_dest, out_result, out_writes_ext, out_commit_flag, out_commit_id},
        {m_blk, m_dst, m_res, m_ext, m_flg, m_cid});
`ifdef COMMIT_TIMEOUT_EN
    chk("timeout_err", timeout_err, m_to);
`endif
    old_vld = m_vld;
    if (enable) begin
      if (rdy != 0) begin
        m_vld = 1; m_blk = b_blk[g]; m_dst = b_dst[g]; m_res = b_res[g];
        m_ext = in_writes_ext[g]; m_flg = in_commit_flag[g]; m_cid = b_id[g];
        m_exp = m_exp + 8'd1;
      end else if (m_vld && out_ready) m_vld = 0;
      if (clear && !old_vld && in_valid == 0) m_exp = 0;
      if (cnt > 1) m_dup = 1;
      if (rdy != 0 || in_valid == 0) m_wd = 0;
      else if (m_wd < TO) m_wd++;
      if (m_wd >= TO) m_to = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst();
    reset = 1; enable = 1; clear = 0; out_ready = 0;
    in_valid = 0; in_writes_ext = 0; in_commit_flag = 0;
    for (int i = 0; i < 4; i++) begin
      b_id[i] = 0; b_blk[i] = 0; b_dst[i] = 0; b_res[i] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_expected_id", expected_id, 0);
    chk("rst_dup_err", dup_err, 0);
    chk("rst_payload", {out_block, out_dest, out_result, out_writes_ext, out_commit_flag, out_commit_id}, 0);
  endtask

  initial begin
    rst();

`ifdef COMMIT_TIMEOUT_EN
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin idle(); put(0, 8'(k)); cyc(); end
    idle(); put(0, 8'd7);
    repeat (TO - 1) cyc();
    chk("t6_not_yet", timeout_err, 0);
    cyc();
    chk("t6_timeout", timeout_err, 1);
    repeat (3) cyc();
    chk("t6_sticky", timeout_err, 1);
    rst();
`endif

    // 1: in-order stream on branch 0
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      idle(); put(0, 8'(k)); cyc();
      chk("t1_cid", out_commit_id, 64'(k));
      chk("t1_vld", out_valid, 1);
    end
    chk("t1_exp", expected_id, 3);

    // 2: out-of-order heads across branches
    idle(); put(1, 8'd4); put(2, 8'd3); cyc();
    chk("t2_rdy_a", last_rdy, 4'b0100);
    chk("t2_cid_a", out_commit_id, 3);
    in_valid[2] = 0; cyc();
    chk("t2_rdy_b", last_rdy, 4'b0010);
    chk("t2_cid_b", out_commit_id, 4);

    // 3: backpressure, then accept and drain in one cycle
    out_ready = 0; idle(); put(0, 8'd5); cyc();
    chk("t3_rdy_blocked", last_rdy, 0);
    chk("t3_hold", out_commit_id, 4);
    out_ready = 1; cyc();
    chk("t3_rdy_go", last_rdy, 4'b0001);
    chk("t3_cid", out_commit_id, 5);
    chk("t3_vld", out_valid, 1);
    chk("t3_exp", expected_id, 6);

    // 4: expected id wraps
    for (int k = 6; k < 255; k++) begin idle(); put(0, 8'(k)); cyc(); end
    chk("t4_exp255", expected_id, 255);
    idle(); put(0, 8'd255); cyc();
    chk("t4_wrap", expected_id, 0);
    idle(); put(0, 8'd0); cyc();
    chk("t4_cid0", out_commit_id, 0);
    chk("t4_exp1", expected_id, 1);

    // 5: duplicate id on two branches
    chk("t5_dup_pre", dup_err, 0);
    idle(); put(0, 8'd1); put(3, 8'd1); cyc();
    chk("t5_rdy", last_rdy, 4'b0001);
    chk("t5_dup", dup_err, 1);
    idle(); repeat (3) cyc();
    chk("t5_dup_sticky", dup_err, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      idle();
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 1) != 0) put(i, m_exp + 8'($urandom_range(0, 3)));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
